// File: rtl/cp0_regs_if.sv
// rtl/cp0_regs_if.sv - write-back stage to CP0 port: reads, MTC0, exception/ERET commit, interrupts
interface cp0_regs_if;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ex_code;
  logic        bd;
  logic        eret;
  logic [31:0] BadVAddr;
  logic        pc_error;
  logic        mtc0;
  logic [4:0]  mtc0_waddr;
  logic [31:0] mtc0_wdata;
  logic [5:0]  ext_int;
  logic        time_int;
  logic        int_req;

  modport master (
    output raddr, waddr, wdata, ex_code, bd, eret, BadVAddr, pc_error,
           mtc0, mtc0_waddr, mtc0_wdata, ext_int,
    input  rdata, time_int, int_req
  );

  modport slave (
    input  raddr, waddr, wdata, ex_code, bd, eret, BadVAddr, pc_error,
           mtc0, mtc0_waddr, mtc0_wdata, ext_int,
    output rdata, time_int, int_req
  );
endinterface

// File: rtl/cp0_regs.sv
// rtl/cp0_regs.sv - CP0 BadVAddr/Count/Compare/Status/Cause/EPC and interrupt logic
// Count/Compare/timer interrupt are built only when CP0_TIMER_EN is defined.
module cp0_regs (
  input  logic         clk,
  input  logic         reset,
  cp0_regs_if.slave    bus
);

  localparam logic [4:0] NO_EX      = 5'h1f;
  localparam logic [4:0] EXC_ADEL   = 5'h04;
  localparam logic [4:0] EXC_ADES   = 5'h05;
  localparam logic [4:0] REG_BADVA  = 5'd8;
  localparam logic [4:0] REG_COUNT  = 5'd9;
  localparam logic [4:0] REG_CMP    = 5'd11;
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  logic [31:0] r_badvaddr;
  logic [31:0] r_epc;
  logic [7:0]  r_status_im;
  logic        r_status_exl;
  logic        r_status_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip_hw;
  logic [1:0]  r_cause_ip_sw;
  logic [4:0]  r_cause_exc;

  logic        w_exc;
  logic        w_eret;
  logic        w_mtc0;
  logic        w_ti;
  logic [31:0] w_count_rd;
  logic [31:0] w_compare_rd;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_rdata;
  logic        w_unused_pc_error;

  // An exception in WB squashes whatever MTC0/ERET the same instruction carries
  assign w_exc  = (bus.ex_code != NO_EX);
  assign w_eret = bus.eret && !w_exc;
  assign w_mtc0 = bus.mtc0 && !w_exc;
  assign w_unused_pc_error = bus.pc_error;

`ifdef CP0_TIMER_EN
  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_cause_ti;
  logic [31:0] w_count_next;
  logic        w_count_wr;
  logic        w_compare_wr;

  assign w_count_wr   = w_mtc0 && (bus.mtc0_waddr == REG_COUNT);
  assign w_compare_wr = w_mtc0 && (bus.mtc0_waddr == REG_CMP);

  always_comb begin
    w_count_next = r_count;
    if (w_count_wr)
      w_count_next = bus.mtc0_wdata;
    else if (r_tick)
      w_count_next = r_count + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick     <= 1'b0;
      r_count    <= 32'd0;
      r_compare  <= 32'd0;
      r_cause_ti <= 1'b0;
    end else begin
      r_tick  <= ~r_tick;
      r_count <= w_count_next;
      if (w_compare_wr)
        r_compare <= bus.mtc0_wdata;
      // A Compare write always acknowledges the timer, even against a same-cycle match
      if (w_compare_wr)
        r_cause_ti <= 1'b0;
      else if (w_count_next == r_compare)
        r_cause_ti <= 1'b1;
    end
  end

  assign w_ti         = r_cause_ti;
  assign w_count_rd   = r_count;
  assign w_compare_rd = r_compare;
`else
  assign w_ti         = 1'b0;
  assign w_count_rd   = 32'd0;
  assign w_compare_rd = 32'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_badvaddr    <= 32'd0;
      r_epc         <= 32'd0;
      r_status_im   <= 8'd0;
      r_status_exl  <= 1'b0;
      r_status_ie   <= 1'b0;
      r_cause_bd    <= 1'b0;
      r_cause_ip_hw <= 6'd0;
      r_cause_ip_sw <= 2'd0;
      r_cause_exc   <= 5'd0;
    end else begin
      r_cause_ip_hw <= {bus.ext_int[5] | w_ti, bus.ext_int[4:0]};
      if (w_exc) begin
        // Nested exceptions keep the original return point and delay-slot flag
        if (!r_status_exl) begin
          if (bus.waddr == REG_EPC)
            r_epc <= bus.bd ? (bus.wdata - 32'd4) : bus.wdata;
          r_cause_bd <= bus.bd;
        end
        r_cause_exc  <= bus.ex_code;
        r_status_exl <= 1'b1;
        if ((bus.ex_code == EXC_ADEL) || (bus.ex_code == EXC_ADES))
          r_badvaddr <= bus.BadVAddr;
      end else begin
        if (w_mtc0) begin
          case (bus.mtc0_waddr)
            REG_STATUS: begin
              r_status_im  <= bus.mtc0_wdata[15:8];
              r_status_exl <= bus.mtc0_wdata[1];
              r_status_ie  <= bus.mtc0_wdata[0];
            end
            REG_CAUSE: r_cause_ip_sw <= bus.mtc0_wdata[9:8];
            REG_EPC:   r_epc         <= bus.mtc0_wdata;
            default: ;
          endcase
        end
        if (w_eret)
          r_status_exl <= 1'b0;
      end
    end
  end

  assign w_status = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
  assign w_cause  = {r_cause_bd, w_ti, 14'd0, r_cause_ip_hw, r_cause_ip_sw,
                     1'b0, r_cause_exc, 2'd0};

  always_comb begin
    w_rdata = 32'd0;
    case (bus.raddr)
      REG_BADVA:  w_rdata = r_badvaddr;
      REG_COUNT:  w_rdata = w_count_rd;
      REG_CMP:    w_rdata = w_compare_rd;
      REG_STATUS: w_rdata = w_status;
      REG_CAUSE:  w_rdata = w_cause;
      REG_EPC:    w_rdata = r_epc;
      default:    w_rdata = 32'd0;
    endcase
  end

  assign bus.rdata    = w_rdata;
  assign bus.time_int = w_ti;
  assign bus.int_req  = (|(w_cause[15:8] & r_status_im)) && r_status_ie && !r_status_exl;

endmodule

// File: tb/tb_cp0_regs.sv
// tb/tb_cp0_regs.sv - directed-vector bench for cp0_regs (both CP0_TIMER_EN builds)
module tb_cp0_regs;

  localparam logic [4:0] NO_EX = 5'h1f;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  logic [31:0] d;
  int   wait_cyc;

  cp0_regs_if bus ();

  cp0_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.raddr      = 5'h1f;
    bus.waddr      = 5'h1f;
    bus.wdata      = 32'd0;
    bus.ex_code    = NO_EX;
    bus.bd         = 1'b0;
    bus.eret       = 1'b0;
    bus.BadVAddr   = 32'd0;
    bus.pc_error   = 1'b0;
    bus.mtc0       = 1'b0;
    bus.mtc0_waddr = 5'd0;
    bus.mtc0_wdata = 32'd0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] q);
    bus.raddr = a;
    #1;
    q = bus.rdata;
    bus.raddr = 5'h1f;
  endtask

  task automatic wb_op(input logic [4:0] ex, input logic [4:0] wa, input logic [31:0] wd,
                       input logic b, input logic [31:0] bva, input logic er,
                       input logic mt, input logic [4:0] ma, input logic [31:0] md);
    bus.ex_code    = ex;
    bus.waddr      = wa;
    bus.wdata      = wd;
    bus.bd         = b;
    bus.BadVAddr   = bva;
    bus.eret       = er;
    bus.mtc0       = mt;
    bus.mtc0_waddr = ma;
    bus.mtc0_wdata = md;
    cycle();
    idle();
  endtask

  task automatic mtc0_wr(input logic [4:0] ma, input logic [31:0] md);
    wb_op(NO_EX, 5'h1f, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, ma, md);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.ext_int = 6'd0;
    idle();
    repeat (2) cycle();

    rd(5'd12, d); check("rst_status", d, 32'h0040_0000);
    rd(5'd13, d); check("rst_cause", d, 32'h0000_0000);
    rd(5'd14, d); check("rst_epc", d, 32'h0000_0000);
    rd(5'd9, d);  check("rst_count", d, 32'h0000_0000);
    check("rst_time_int", {31'd0, bus.time_int}, 32'd0);
    check("rst_int_req", {31'd0, bus.int_req}, 32'd0);
    reset = 1'b0;

    // Park Compare far away so the reset-time Count==Compare match is acknowledged
    mtc0_wr(5'd11, 32'hFFFF_0000);
    repeat (2) cycle();

    wb_op(5'h04, 5'd14, 32'hBFC0_0104, 1'b1, 32'h1234_5671, 1'b0, 1'b0, 5'd0, 32'd0);
    rd(5'd14, d); check("exc1_epc", d, 32'hBFC0_0100);
    rd(5'd13, d); check("exc1_cause", d, 32'h8000_0010);
    rd(5'd8, d);  check("exc1_badva", d, 32'h1234_5671);
    rd(5'd12, d); check("exc1_status", d, 32'h0040_0002);

    wb_op(5'h05, 5'd14, 32'h8000_0200, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'd0);
    rd(5'd14, d); check("exc2_epc_kept", d, 32'hBFC0_0100);
    rd(5'd13, d); check("exc2_cause", d, 32'h8000_0014);
    rd(5'd8, d);  check("exc2_badva", d, 32'hDEAD_BEEF);

    wb_op(NO_EX, 5'h1f, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    rd(5'd12, d); check("eret_status", d, 32'h0040_0000);

    wb_op(5'h08, 5'd14, 32'h8000_1000, 1'b0, 32'h0BAD_0BAD, 1'b1, 1'b0, 5'd0, 32'd0);
    rd(5'd12, d); check("exc_eret_status", d, 32'h0040_0002);
    rd(5'd14, d); check("exc_eret_epc", d, 32'h8000_1000);
    rd(5'd13, d); check("exc_eret_cause", d, 32'h0000_0020);
    rd(5'd8, d);  check("syscall_badva_kept", d, 32'hDEAD_BEEF);
    wb_op(NO_EX, 5'h1f, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    rd(5'd12, d); check("eret2_status", d, 32'h0040_0000);

`ifdef CP0_TIMER_EN
    mtc0_wr(5'd9, 32'd0);
    rd(5'd9, d); check("count_written", d, 32'd0);
    mtc0_wr(5'd11, 32'd5);
    check("ti_clear_cmp5", {31'd0, bus.time_int}, 32'd0);
    wait_cyc = 0;
    while (!bus.time_int && wait_cyc < 40) begin
      cycle();
      wait_cyc++;
    end
    check("ti_rise", {31'd0, bus.time_int}, 32'd1);
    check("ti_latency_ok", {31'd0, (wait_cyc >= 7 && wait_cyc <= 12)}, 32'd1);
    rd(5'd9, d);  check("count_at_ti", d, 32'd5);
    rd(5'd13, d); check("cause_ti_bit", {31'd0, d[30]}, 32'd1);
    mtc0_wr(5'd11, 32'd20);
    check("ti_clear_cmp20", {31'd0, bus.time_int}, 32'd0);
    mtc0_wr(5'd11, 32'hFFFF_0000);
`else
    mtc0_wr(5'd9, 32'h0000_0055);
    rd(5'd9, d);  check("count_disabled", d, 32'd0);
    mtc0_wr(5'd11, 32'd5);
    rd(5'd11, d); check("compare_disabled", d, 32'd0);
    repeat (12) cycle();
    check("ti_disabled", {31'd0, bus.time_int}, 32'd0);
    repeat (2) cycle();
`endif

    mtc0_wr(5'd12, 32'h0040_8001);
    rd(5'd12, d); check("status_written", d, 32'h0040_8001);
    check("int_req_no_src", {31'd0, bus.int_req}, 32'd0);
    bus.ext_int = 6'b100000;
    cycle();
    check("int_req_ext5", {31'd0, bus.int_req}, 32'd1);
    rd(5'd13, d); check("cause_ip15", d, 32'h0000_8020);

    wb_op(5'h0c, 5'h1f, 32'h1111_1110, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("int_req_exl", {31'd0, bus.int_req}, 32'd0);
    rd(5'd12, d); check("status_exl_set", d, 32'h0040_8003);
    rd(5'd14, d); check("epc_idle_waddr", d, 32'h8000_1000);

    wb_op(NO_EX, 5'h1f, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    rd(5'd12, d); check("eret3_status", d, 32'h0040_8001);
    wb_op(5'h0c, 5'h1f, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd12, 32'h0000_FF00);
    rd(5'd12, d); check("exc_beats_mtc0", d, 32'h0040_8003);

    mtc0_wr(5'd13, 32'h0000_0300);
    rd(5'd13, d); check("cause_ip_sw", d, 32'h0000_8330);
    mtc0_wr(5'd8, 32'd0);
    rd(5'd8, d);  check("badva_readonly", d, 32'hDEAD_BEEF);
    rd(5'd10, d); check("unmapped_read", d, 32'd0);

    reset = 1'b1;
    #1;
    rd(5'd12, d); check("async_rst_status", d, 32'h0040_0000);
    rd(5'd14, d); check("async_rst_epc", d, 32'd0);
    rd(5'd8, d);  check("async_rst_badva", d, 32'd0);
    check("async_rst_int_req", {31'd0, bus.int_req}, 32'd0);
    bus.ext_int = 6'd0;
    cycle();
    reset = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
